// File: rtl/mem_pkg.sv
// Shared definitions for the memory-port arbiter: access codes, owner
// identifiers and FSM state encodings.
package mem_pkg;

  // Load access codes (bit 3 clear).
  localparam logic [3:0] LOAD8  = 4'b0000;
  localparam logic [3:0] LOAD2  = 4'b0001;
  localparam logic [3:0] LOAD1  = 4'b0010;
  localparam logic [3:0] LOAD4S = 4'b0011;
  localparam logic [3:0] LOAD2S = 4'b0100;
  localparam logic [3:0] LOAD4  = 4'b0101;

  // Store access codes (bit 3 set).
  localparam logic [3:0] STORE8 = 4'b1000;
  localparam logic [3:0] STORE4 = 4'b1001;
  localparam logic [3:0] STORE2 = 4'b1010;
  localparam logic [3:0] STORE1 = 4'b1011;

  // Instruction fetches are always 4-byte zero-extended loads.
  localparam logic [3:0] IFU_CTRL = LOAD4;

  // Which requester owns the in-flight transaction.
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  // Sequencer states, kept as plain constants for legacy tooling.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Stores return no data; only loads forward the memory read data.
  function automatic logic is_store(input logic [3:0] ctrl);
    return ctrl[3];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. A lone requester always wins; on a tie the
// requester that was not served last wins.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic [1:0] grant
);

  // Pick at most one winner; bit 0 is the IFU, bit 1 the LSU.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == OWN_LSU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer for the single data-memory port shared by the
// instruction fetch unit and the load/store unit. One transaction is in
// flight at a time; the response is returned to its owner as a registered
// one-cycle pulse, and a watchdog aborts a request the memory never answers.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_ctrl,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_ctrl,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              timeout_err
);

  // Last counter value allowed in WAIT before the request is abandoned.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]        state;
  owner_t            owner;
  owner_t            rr_last;
  logic [15:0]       wait_cnt;
  logic [1:0]        grant;
  logic              resp_hit;
  logic              time_up;
  logic              finish;
  logic [DATA_W-1:0] resp_data;

  rr_arb2 u_rr_arb2 (
    .req   ({lsu_req_valid, ifu_req_valid}),
    .last  (rr_last),
    .grant (grant)
  );

  // Handshake outputs and WAIT-exit conditions; a response on the final
  // WAIT cycle takes priority over the watchdog.
  always_comb begin
    ifu_req_ready = (state == ST_IDLE) && grant[0];
    lsu_req_ready = (state == ST_IDLE) && grant[1];
    mem_req_valid = (state == ST_REQ);
    resp_hit      = (state == ST_WAIT) && mem_resp_valid;
    time_up       = (state == ST_WAIT) && !mem_resp_valid && (wait_cnt == WAIT_LAST);
    finish        = resp_hit || time_up;
    resp_data     = (resp_hit && !is_store(mem_ctrl)) ? mem_rdata : '0;
  end

  // Sequencer: accept a request, hold it on the memory port, await the reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IFU;
      rr_last   <= OWN_LSU;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ctrl  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ifu_req_ready) begin
            mem_addr  <= ifu_addr;
            mem_wdata <= '0;
            mem_ctrl  <= IFU_CTRL;
            owner     <= OWN_IFU;
            rr_last   <= OWN_IFU;
            state     <= ST_REQ;
          end else if (lsu_req_ready) begin
            mem_addr  <= lsu_addr;
            mem_wdata <= lsu_wdata;
            mem_ctrl  <= lsu_ctrl;
            owner     <= OWN_LSU;
            rr_last   <= OWN_LSU;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (finish) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Watchdog counter: cleared as the memory accepts, advances every WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state == ST_REQ) && mem_req_ready) begin
      wait_cnt <= '0;
    end else if ((state == ST_WAIT) && !finish) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Response pulses to the owner, held read data, and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_rdata      <= '0;
      timeout_err    <= 1'b0;
    end else begin
      ifu_resp_valid <= finish && (owner == OWN_IFU);
      lsu_resp_valid <= finish && (owner == OWN_LSU);
      if (finish && (owner == OWN_IFU)) begin
        ifu_rdata <= resp_data;
      end
      if (finish && (owner == OWN_LSU)) begin
        lsu_rdata <= resp_data;
      end
      if (time_up) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Each accepted transaction is planned at transaction
// level (memory stall length and response delay), from which the cycle of
// every expected handshake, stable memory request and response pulse follows.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_ctrl;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_ctrl;
  logic        timeout_err;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_ctrl(lsu_ctrl), .lsu_resp_valid(lsu_resp_valid),
    .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ctrl(mem_ctrl), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Reference model of the transaction in flight.
  bit          active = 1'b0;
  bit          tmo = 1'b0;
  bit          own_lsu = 1'b0;
  bit          rr_last_lsu = 1'b1;
  bit          exp_terr = 1'b0;
  bit          post_rst = 1'b0;
  int          rdy_cyc, wait_start, resp_at, pulse_cyc;
  logic [63:0] e_addr, e_wdata, e_data, planned_rdata;
  logic [3:0]  e_ctrl;
  logic [63:0] exp_ifu_rdata = '0;
  logic [63:0] exp_lsu_rdata = '0;

  // Stimulus knobs.
  bit          do_rst, use_fixed, noise_en, force_resp;
  int          p_ifu, p_lsu, f_dr, f_k;
  logic [63:0] fx_ifu_addr, fx_lsu_addr, fx_lsu_wdata, fx_rdata;
  logic [3:0]  fx_lsu_ctrl;
  logic [3:0]  lsu_codes [10];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance the model.
  task automatic applyStimulus();
    bit busy, in_wait, exp_gi, exp_gl, exp_mv, exp_ip, exp_lp, noise_r, noise_v;
    int dr, k;
    @(negedge clk);
    rst = do_rst;
    busy = active && (cyc < pulse_cyc);

    ifu_req_valid = ($urandom_range(0, 99) < p_ifu);
    lsu_req_valid = ($urandom_range(0, 99) < p_lsu);
    if (use_fixed) begin
      ifu_addr  = fx_ifu_addr;
      lsu_addr  = fx_lsu_addr;
      lsu_wdata = fx_lsu_wdata;
      lsu_ctrl  = fx_lsu_ctrl;
    end else begin
      ifu_addr  = {$urandom, $urandom};
      lsu_addr  = {$urandom, $urandom};
      lsu_wdata = {$urandom, $urandom};
      lsu_ctrl  = lsu_codes[$urandom_range(0, 9)];
    end

    noise_r = noise_en && ($urandom_range(0, 3) == 0);
    noise_v = noise_en && ($urandom_range(0, 3) == 0);
    mem_req_ready = busy ? ((cyc == rdy_cyc) || ((cyc > rdy_cyc) && noise_r)) : noise_r;
    in_wait = busy && (cyc >= wait_start);
    mem_resp_valid = in_wait ? (!tmo && (cyc == resp_at)) : noise_v;
    if (force_resp) mem_resp_valid = 1'b1;
    mem_rdata = (busy && (cyc == resp_at)) ? planned_rdata : {$urandom, $urandom};

    #1;
    exp_ip = 1'b0;
    exp_lp = 1'b0;
    exp_gi = 1'b0;
    exp_gl = 1'b0;
    if (!do_rst) begin
      if (active && (cyc == pulse_cyc)) begin
        exp_ip = !own_lsu;
        exp_lp = own_lsu;
        if (own_lsu) exp_lsu_rdata = e_data;
        else         exp_ifu_rdata = e_data;
        if (tmo) exp_terr = 1'b1;
      end
      if (!busy) begin
        exp_gi = ifu_req_valid && (!lsu_req_valid || rr_last_lsu);
        exp_gl = lsu_req_valid && (!ifu_req_valid || !rr_last_lsu);
      end
      exp_mv = busy && (cyc <= rdy_cyc);
      checkOutput("ifu_req_ready", 64'(ifu_req_ready), 64'(exp_gi));
      checkOutput("lsu_req_ready", 64'(lsu_req_ready), 64'(exp_gl));
      checkOutput("mem_req_valid", 64'(mem_req_valid), 64'(exp_mv));
      if (exp_mv) begin
        checkOutput("mem_addr", mem_addr, e_addr);
        checkOutput("mem_wdata", mem_wdata, e_wdata);
        checkOutput("mem_ctrl", 64'(mem_ctrl), 64'(e_ctrl));
      end
      if (post_rst) begin
        checkOutput("rst_mem_addr", mem_addr, 64'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 64'h0);
        checkOutput("rst_mem_ctrl", 64'(mem_ctrl), 64'h0);
        post_rst = 1'b0;
      end
      checkOutput("ifu_resp_valid", 64'(ifu_resp_valid), 64'(exp_ip));
      checkOutput("lsu_resp_valid", 64'(lsu_resp_valid), 64'(exp_lp));
      checkOutput("ifu_rdata", ifu_rdata, exp_ifu_rdata);
      checkOutput("lsu_rdata", lsu_rdata, exp_lsu_rdata);
      checkOutput("timeout_err", 64'(timeout_err), 64'(exp_terr));

      if (active && (cyc == pulse_cyc)) active = 1'b0;
      if (exp_gi || exp_gl) begin
        active      = 1'b1;
        own_lsu     = exp_gl;
        rr_last_lsu = exp_gl;
        e_addr      = exp_gl ? lsu_addr : ifu_addr;
        e_wdata     = exp_gl ? lsu_wdata : 64'h0;
        e_ctrl      = exp_gl ? lsu_ctrl : 4'b0101;
        dr = (f_dr >= 0) ? f_dr : int'($urandom_range(0, 3));
        k  = (f_k >= 0) ? f_k : int'($urandom_range(0, TMO + 2));
        rdy_cyc    = cyc + 1 + dr;
        wait_start = rdy_cyc + 1;
        planned_rdata = use_fixed ? fx_rdata : {$urandom, $urandom};
        if (k < TMO) begin
          tmo       = 1'b0;
          resp_at   = wait_start + k;
          pulse_cyc = resp_at + 1;
          e_data    = e_ctrl[3] ? 64'h0 : planned_rdata;
        end else begin
          tmo       = 1'b1;
          resp_at   = -1;
          pulse_cyc = wait_start + TMO;
          e_data    = 64'h0;
        end
      end
    end else begin
      active        = 1'b0;
      rr_last_lsu   = 1'b1;
      exp_terr      = 1'b0;
      exp_ifu_rdata = '0;
      exp_lsu_rdata = '0;
      post_rst      = 1'b1;
    end
    @(posedge clk);
    cyc++;
  endtask

  // Let the current transaction finish with no new requests.
  task automatic drain();
    int n = 0;
    p_ifu = 0;
    p_lsu = 0;
    while (active && (cyc <= pulse_cyc) && (n < 60)) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_bound", 64'(n >= 60), 64'h0);
  endtask

  task automatic resetCycle();
    do_rst = 1'b1;
    applyStimulus();
    do_rst = 1'b0;
  endtask

  initial begin
    int n;
    lsu_codes = '{LOAD8, LOAD2, LOAD1, LOAD4S, LOAD2S, LOAD4, STORE8, STORE4, STORE2, STORE1};
    rst = 1'b1;
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
    ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_ctrl = '0; mem_rdata = '0;
    do_rst = 1'b1; use_fixed = 1'b0; noise_en = 1'b0; force_resp = 1'b0;
    p_ifu = 0; p_lsu = 0; f_dr = -1; f_k = -1;
    fx_ifu_addr = '0; fx_lsu_addr = '0; fx_lsu_wdata = '0; fx_rdata = '0; fx_lsu_ctrl = '0;
    repeat (2) applyStimulus();
    do_rst = 1'b0;

    $display("[TB] IFU fetch, minimum latency");
    use_fixed = 1'b1; fx_ifu_addr = 64'h8000_0000; fx_rdata = 64'h13;
    f_dr = 0; f_k = 0; p_ifu = 100; p_lsu = 0;
    applyStimulus();
    drain();
    checkOutput("fetch_rdata", ifu_rdata, 64'h13);

    $display("[TB] both requesters held valid after reset");
    resetCycle();
    use_fixed = 1'b0; f_dr = -1; f_k = 1;
    for (int i = 0; i < 4; i++) begin
      p_ifu = 100; p_lsu = 100;
      n = 0;
      while (n < 12) begin
        applyStimulus();
        n++;
        if (active && (cyc < pulse_cyc)) n = 12;
      end
      drain();
      checkOutput("alt_owner", 64'(own_lsu), 64'(i % 2));
    end

    $display("[TB] LSU store with stalled memory");
    use_fixed = 1'b1; fx_lsu_ctrl = STORE4; fx_lsu_addr = 64'h8000_1000;
    fx_lsu_wdata = 64'hDEAD_BEEF; fx_rdata = 64'h5555_AAAA;
    f_dr = 3; f_k = 1; p_lsu = 100;
    applyStimulus();
    drain();
    checkOutput("store_rdata", lsu_rdata, 64'h0);

    $display("[TB] watchdog timeout then normal fetch");
    fx_ifu_addr = 64'h8000_0040; f_dr = 0; f_k = TMO + 3; p_ifu = 100;
    applyStimulus();
    drain();
    checkOutput("tmo_flag", 64'(timeout_err), 64'h1);
    f_k = 1; fx_rdata = 64'h1234_5678; p_ifu = 100;
    applyStimulus();
    drain();
    checkOutput("tmo_sticky", 64'(timeout_err), 64'h1);

    $display("[TB] reset during WAIT");
    fx_lsu_ctrl = LOAD8; f_dr = 1; f_k = TMO + 3; p_lsu = 100;
    n = 0;
    while (!(active && (cyc >= wait_start) && (cyc < pulse_cyc)) && (n < 20)) begin
      applyStimulus();
      p_lsu = 0;
      n++;
    end
    checkOutput("wait_reach_bound", 64'(n >= 20), 64'h0);
    p_ifu = 0; p_lsu = 0;
    resetCycle();
    force_resp = 1'b1;
    applyStimulus();
    force_resp = 1'b0;
    repeat (3) applyStimulus();

    $display("[TB] response on final WAIT cycle");
    fx_rdata = 64'hCAFE_F00D; f_dr = 0; f_k = TMO - 1; p_lsu = 100;
    applyStimulus();
    drain();
    checkOutput("final_wait_rdata", lsu_rdata, 64'hCAFE_F00D);
    checkOutput("final_wait_terr", 64'(timeout_err), 64'h0);

    $display("[TB] randomized traffic");
    use_fixed = 1'b0; noise_en = 1'b1; f_dr = -1; f_k = -1;
    for (int i = 0; i < 1500; i++) begin
      p_ifu = 50; p_lsu = 50;
      do_rst = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end
    do_rst = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single data-memory port. Requesters are the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time, drives it onto the memory port with a valid/ready handshake, and waits for the response. Routes the response back to the owner as a registered one-cycle pulse.
- Sits between IFU/LSU and the memory access block. Round-robin fairness; a response-timeout watchdog flags a hung memory.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- TIMEOUT, 255, maximum cycles spent in WAIT before aborting; legal range 1..65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_resp_valid  out  1  one-cycle fetch response pulse.
- ifu_rdata  out  DATA_W  fetch data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wdata  in  DATA_W  store data.
- lsu_ctrl  in  4  access code; bit3=1 store, 0 load.
- lsu_resp_valid  out  1  one-cycle load data / store ack pulse.
- lsu_rdata  out  DATA_W  load data; 0 for stores.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched store data.
- mem_ctrl  out  4  latched access code.
- mem_resp_valid  in  1  memory response.
- mem_rdata  in  DATA_W  memory read data.
- timeout_err  out  1  sticky: a WAIT timeout occurred.

Behaviour:
- Reset values: state=IDLE, all *_ready/*_valid=0, rdata outputs=0, mem_addr/wdata/ctrl=0, timeout_err=0, counter=0, rr_last=LSU (IFU wins the first tie).
- Access codes:
  - 0000 load8, 0001 load2, 0010 load1, 0011 load4-sext, 0100 load2-sext, 0101 load4.
  - 1000 store8, 1001 store4, 1010 store2, 1011 store1.
  - IFU requests always use code 0101 with wdata=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - *_req_ready is combinational, asserted only in IDLE and only to the winner.
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to rr_last wins.
  - On handshake: latch addr/wdata/ctrl and owner into registers, set rr_last=owner, go to REQ.
- REQ:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_ready: counter=0, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - mem_resp_valid: next cycle the owner's resp_valid=1 for exactly one cycle. Its rdata = mem_rdata for loads, 0 for stores. Go to IDLE.
  - Counter reaches TIMEOUT-1 without a response: set timeout_err; owner gets a resp_valid pulse with rdata=0; go to IDLE.
  - mem_resp_valid in the same cycle as the timeout: the response wins and timeout_err is not set.
- rdata outputs hold their last value between pulses. The non-owner's resp_valid stays 0.
- mem_resp_valid outside WAIT is ignored.
- mem_req_ready outside REQ is ignored.
- Minimum latency: accept at cycle t, mem_req_valid at t+1. With ready at t+1 and response at t+2, resp_valid rises at t+3.
- Back-to-back: a new request is accepted in the IDLE cycle in which the previous resp_valid pulse is high.
- Reset mid-operation: the in-flight request is dropped with no response pulse. timeout_err is cleared only by rst.

Decomposition:
- Shared package `mem_pkg`:
  - Access-code constants (LOAD8..STORE1), plus an owner enum (OWN_IFU, OWN_LSU).
  - FSM state enum (ST_IDLE, ST_REQ, ST_WAIT).
- One natural sub-module, `rr_arb2`: a combinational 2-way round-robin picker (inputs req[1:0], last; output grant[1:0]). The FSM, latches and watchdog stay in mem_arbiter.

Test Plan:
- IFU only, addr=0x80000000, ready immediate, response next cycle with rdata=0x00000013 -> mem_ctrl=0101; ifu_resp_valid pulses at t+3 with ifu_rdata=0x13; lsu_resp_valid stays 0.
- Both requesters valid right after reset, then held valid -> grants alternate IFU, LSU, IFU, LSU across 4 transactions.
- LSU store, ctrl=1001, addr=0x80001000, wdata=0xDEADBEEF, mem_req_ready low 3 cycles -> mem_* fields stable all 3 cycles; lsu_resp_valid pulses with lsu_rdata=0.
- TIMEOUT=4, memory never responds -> timeout_err=1 after 4 WAIT cycles; owner gets a pulse with rdata=0; next request is served normally; timeout_err stays 1.
- rst asserted during WAIT -> next cycle all outputs at reset values; no resp pulse; a late mem_resp_valid is ignored.
- mem_resp_valid arrives on the final WAIT cycle -> normal response delivered; timeout_err stays 0.
